operand_entry: RTL

OPERAND_ENTRY -- requirements
Module: operand_entry

---
 rtl/operand_entry_pkg.sv | 16 +
 rtl/operand_entry_key_edge.sv | 29 ++
 rtl/operand_entry.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/operand_entry_pkg.sv
// Shared definitions for the calculator operand-entry block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package operand_entry_pkg;

    // BCD digit width in bits.
    localparam int BCD_W = 4;

    // Entry state: building operand A, building operand B, result waiting for consumer.
    typedef enum logic [1:0] {
        ENTA = 2'd0,
        ENTB = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/operand_entry_key_edge.sv
// Rising-edge detector for a vector of clk-synchronous key levels.
// Latency: combinational rise output against a one-cycle history register.
// Backpressure: none; every cycle is evaluated.
// Ports: clk, rst (sync, active-high), i_lvl[W] key levels, o_rise[W] rising-edge pulses.
module key_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_lvl,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_hist;

    // Reset loads the live levels so a key held through reset never looks like a new press.
    // Outside reset the history simply follows the levels every cycle, whatever the
    // consumer does with the resulting edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= i_lvl;
        end else begin
            r_hist <= i_lvl;
        end
    end

    assign o_rise = i_lvl & ~r_hist;

endmodule

// File: rtl/operand_entry.sv
// Calculator operand entry: turns key presses into two BCD operands plus an operator.
// Latency: a key rising in cycle N is reflected in registered outputs in cycle N+1.
// Backpressure: result held in DONE with out_valid until out_ready; only clr or rst abort it.
// Ports: clk/rst; key_digit[10], key_op[NOPS], key_eq, key_bs, key_clr key levels;
//        cur_bcd/cur_len/in_b/ovf/key_err status; out_valid/out_ready handshake with
//        opa_bcd, opb_bcd, op_sel (one-hot) payload.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int NOPS    = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [9:0]                        key_digit,
    input  logic [NOPS-1:0]                   key_op,
    input  logic                              key_eq,
    input  logic                              key_bs,
    input  logic                              key_clr,
    output logic [BCD_W*NDIGITS-1:0]          cur_bcd,
    output logic [$clog2(NDIGITS+1)-1:0]      cur_len,
    output logic                              in_b,
    output logic                              ovf,
    output logic                              key_err,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [BCD_W*NDIGITS-1:0]          opa_bcd,
    output logic [BCD_W*NDIGITS-1:0]          opb_bcd,
    output logic [NOPS-1:0]                   op_sel
);

    localparam int DW = BCD_W * NDIGITS;
    localparam int LW = $clog2(NDIGITS + 1);
    // Key vector layout: [9:0] digits, then operators, then eq, bs, clr (clr on top).
    localparam int NK = 10 + NOPS + 3;

    logic [NK-1:0]   w_lvl;
    logic [NK-1:0]   w_rise;
    logic [NK-2:0]   w_ev;
    logic            w_multi;
    logic [9:0]      w_dig_rise;
    logic [NOPS-1:0] w_op_rise;
    logic            w_eq_ev;
    logic            w_bs_ev;
    logic            w_clr_ev;
    logic [3:0]      w_dig_idx;

    state_t          r_state, w_nxt_state;
    logic [DW-1:0]   r_cur_bcd, w_nxt_cur_bcd;
    logic [LW-1:0]   r_cur_len, w_nxt_cur_len;
    logic            r_ovf, w_nxt_ovf;
    logic            r_key_err, w_nxt_key_err;
    logic            r_out_valid, w_nxt_out_valid;
    logic [DW-1:0]   r_opa, w_nxt_opa;
    logic [DW-1:0]   r_opb, w_nxt_opb;
    logic [NOPS-1:0] r_op_sel, w_nxt_op_sel;

    assign w_lvl = {key_clr, key_bs, key_eq, key_op, key_digit};

    key_edge #(.W(NK)) u_key_edge (
        .clk    (clk),
        .rst    (rst),
        .i_lvl  (w_lvl),
        .o_rise (w_rise)
    );

    assign w_dig_rise = w_rise[9:0];
    assign w_op_rise  = w_rise[10 +: NOPS];
    assign w_eq_ev    = w_rise[10 + NOPS];
    assign w_bs_ev    = w_rise[11 + NOPS];
    assign w_clr_ev   = w_rise[12 + NOPS];

    // All non-clr events; clearing the lowest set bit leaves something only if two or more fired.
    assign w_ev    = w_rise[NK-2:0];
    assign w_multi = |(w_ev & (w_ev - 1'b1));

    // Digit index; only meaningful when exactly one digit rose.
    always_comb begin
        w_dig_idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (w_dig_rise[i]) begin
                w_dig_idx = 4'(i);
            end
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cur_bcd   = r_cur_bcd;
        w_nxt_cur_len   = r_cur_len;
        w_nxt_ovf       = r_ovf;
        w_nxt_key_err   = 1'b0;
        w_nxt_out_valid = r_out_valid;
        w_nxt_opa       = r_opa;
        w_nxt_opb       = r_opb;
        w_nxt_op_sel    = r_op_sel;

        if (w_clr_ev) begin
            w_nxt_state     = ENTA;
            w_nxt_cur_bcd   = '0;
            w_nxt_cur_len   = '0;
            w_nxt_ovf       = 1'b0;
            w_nxt_out_valid = 1'b0;
            w_nxt_opa       = '0;
            w_nxt_opb       = '0;
            w_nxt_op_sel    = '0;
        end else begin
            if (w_multi) begin
                w_nxt_key_err = 1'b1;
            end
            case (r_state)
                ENTA, ENTB: begin
                    if (!w_multi) begin
                        if (|w_dig_rise) begin
                            if (r_cur_len == LW'(NDIGITS)) begin
                                w_nxt_ovf = 1'b1;
                            end else if (!(w_dig_idx == 4'd0 && r_cur_len == '0)) begin
                                w_nxt_cur_bcd = (r_cur_bcd << BCD_W) | DW'(w_dig_idx);
                                w_nxt_cur_len = r_cur_len + 1'b1;
                            end
                        end else if (w_bs_ev) begin
                            if (r_cur_len != '0) begin
                                w_nxt_cur_bcd = r_cur_bcd >> BCD_W;
                                w_nxt_cur_len = r_cur_len - 1'b1;
                            end
                        end else if (|w_op_rise) begin
                            w_nxt_op_sel = w_op_rise;
                            if (r_state == ENTA) begin
                                w_nxt_opa     = r_cur_bcd;
                                w_nxt_cur_bcd = '0;
                                w_nxt_cur_len = '0;
                                w_nxt_ovf     = 1'b0;
                                w_nxt_state   = ENTB;
                            end
                        end else if (w_eq_ev && r_state == ENTB) begin
                            w_nxt_opb       = r_cur_bcd;
                            w_nxt_out_valid = 1'b1;
                            w_nxt_state     = DONE;
                        end
                    end
                end
                DONE: begin
                    // Payload stays frozen; only the handshake moves us on.
                    if (r_out_valid && out_ready) begin
                        w_nxt_out_valid = 1'b0;
                        w_nxt_state     = ENTA;
                        w_nxt_cur_bcd   = '0;
                        w_nxt_cur_len   = '0;
                        w_nxt_ovf       = 1'b0;
                    end
                end
                default: begin
                    w_nxt_state = ENTA;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ENTA;
            r_cur_bcd   <= '0;
            r_cur_len   <= '0;
            r_ovf       <= 1'b0;
            r_key_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_op_sel    <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_cur_bcd   <= w_nxt_cur_bcd;
            r_cur_len   <= w_nxt_cur_len;
            r_ovf       <= w_nxt_ovf;
            r_key_err   <= w_nxt_key_err;
            r_out_valid <= w_nxt_out_valid;
            r_opa       <= w_nxt_opa;
            r_opb       <= w_nxt_opb;
            r_op_sel    <= w_nxt_op_sel;
        end
    end

    assign cur_bcd   = r_cur_bcd;
    assign cur_len   = r_cur_len;
    assign in_b      = (r_state == ENTB);
    assign ovf       = r_ovf;
    assign key_err   = r_key_err;
    assign out_valid = r_out_valid;
    assign opa_bcd   = r_opa;
    assign opb_bcd   = r_opb;
    assign op_sel    = r_op_sel;

endmodule
